// File: rtl/airi5c_uart_tx_arbiter.sv
// airi5c_uart_tx_arbiter: round-robin AHB-Lite master sharing one airi5c_uart TX path.
// Define UART_ARB_PACKET_EN to hold a grant on one requester until its req_last byte.
module airi5c_uart_tx_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_REQ   = 4,
  parameter int          TX_DEPTH  = 32
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [31:0]          haddr,
  output logic                 hwrite,
  output logic [1:0]           htrans,
  output logic [31:0]          hwdata,
  input  logic [31:0]          hrdata,
  input  logic                 hready,
  input  logic                 hresp,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);
  // state    | meaning
  // IDLE     | nothing to send, or halted by sticky err
  // POLL_A   | TX_STAT read address phase
  // POLL_D   | TX_STAT read data phase, reload credit
  // ARB      | round-robin pick, latch byte, pulse req_ready
  // WR_A     | DATA write address phase
  // WR_D     | DATA write data phase, consume one credit

  localparam int          CW        = $clog2(TX_DEPTH + 1);
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd16;
  localparam logic [1:0]  HT_IDLE   = 2'd0;
  localparam logic [1:0]  HT_NONSEQ = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_POLL_A, ST_POLL_D, ST_ARB, ST_WR_A, ST_WR_D
  } state_t;

  state_t        state;
  logic [2:0]    rr_ptr;
  logic [CW-1:0] credit;
  logic [CW-1:0] credit_dec;
  logic [CW-1:0] poll_credit;
  logic          pick_found;
  logic [2:0]    pick_idx;
  logic [7:0]    pick_data;
  logic          pick_last;
  logic [2:0]    rr_next;
  logic [7:0]    valid8;
  logic [7:0]    last8;
  logic [63:0]   data64;
  logic          unused_bits;
`ifdef UART_ARB_PACKET_EN
  logic          locked;
  logic [2:0]    lock_id;
`endif

  assign busy        = (state != ST_IDLE);
  assign credit_dec  = credit - CW'(1);
  assign rr_next     = (pick_idx == 3'(NUM_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;
  assign unused_bits = ^{hrdata[31:8], pick_last};

  // Free FIFO slots from the fill level; an over-full report yields no credit.
  always_comb begin
    int room;
    room = TX_DEPTH - int'(hrdata[7:0]);
    poll_credit = (room > 0) ? CW'(room) : '0;
  end

  always_comb begin
    logic [3:0] sum;
    logic [2:0] j3;
    sum        = '0;
    j3         = '0;
    valid8     = 8'(req_valid);
    last8      = 8'(req_last);
    data64     = 64'(req_data);
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + 4'(k);
      if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
      j3 = sum[2:0];
      if (!pick_found && valid8[j3]) begin
        pick_found = 1'b1;
        pick_idx   = j3;
      end
    end
`ifdef UART_ARB_PACKET_EN
    if (locked) begin
      pick_found = valid8[lock_id];
      pick_idx   = lock_id;
    end
`endif
    pick_data = data64[{pick_idx, 3'b000} +: 8];
    pick_last = last8[pick_idx];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= 3'd0;
      credit    <= '0;
      req_ready <= '0;
      haddr     <= 32'd0;
      hwrite    <= 1'b0;
      htrans    <= HT_IDLE;
      hwdata    <= 32'd0;
      grant_id  <= 3'd0;
      err       <= 1'b0;
`ifdef UART_ARB_PACKET_EN
      locked    <= 1'b0;
      lock_id   <= 3'd0;
`endif
    end else begin
      req_ready <= '0;
      htrans    <= HT_IDLE;
      if (err_clr) err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!err && |req_valid) begin
            if (credit == '0) begin
              state  <= ST_POLL_A;
              haddr  <= STAT_ADDR;
              hwrite <= 1'b0;
              htrans <= HT_NONSEQ;
            end else begin
              state <= ST_ARB;
            end
          end
        end
        ST_POLL_A: state <= ST_POLL_D;
        ST_POLL_D: begin
          // Error response wins over err_clr and drops any remaining credit.
          if (hresp) begin
            err    <= 1'b1;
            credit <= '0;
            state  <= ST_IDLE;
`ifdef UART_ARB_PACKET_EN
            locked <= 1'b0;
`endif
          end else if (hready) begin
            credit <= poll_credit;
            if (poll_credit != '0) begin
              state <= ST_ARB;
            end else begin
              state  <= ST_POLL_A;
              haddr  <= STAT_ADDR;
              hwrite <= 1'b0;
              htrans <= HT_NONSEQ;
            end
          end
        end
        ST_ARB: begin
          if (pick_found) begin
            req_ready <= NUM_REQ'(8'b1 << pick_idx);
            grant_id  <= pick_idx;
            hwdata    <= {24'b0, pick_data};
            haddr     <= BASE_ADDR;
            hwrite    <= 1'b1;
            htrans    <= HT_NONSEQ;
            state     <= ST_WR_A;
`ifdef UART_ARB_PACKET_EN
            locked    <= !pick_last;
            lock_id   <= pick_idx;
            if (pick_last) rr_ptr <= rr_next;
`else
            rr_ptr    <= rr_next;
`endif
          end else begin
`ifdef UART_ARB_PACKET_EN
            if (!locked) state <= ST_IDLE;
`else
            state <= ST_IDLE;
`endif
          end
        end
        ST_WR_A: state <= ST_WR_D;
        ST_WR_D: begin
          if (hresp) begin
            err    <= 1'b1;
            credit <= '0;
            state  <= ST_IDLE;
`ifdef UART_ARB_PACKET_EN
            locked <= 1'b0;
`endif
          end else if (hready) begin
            credit <= credit_dec;
            if (credit_dec != '0) begin
              state <= ST_ARB;
            end else if (|req_valid) begin
              state  <= ST_POLL_A;
              haddr  <= STAT_ADDR;
              hwrite <= 1'b0;
              htrans <= HT_NONSEQ;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_airi5c_uart_tx_arbiter.sv
// Bench for airi5c_uart_tx_arbiter: byte-queue requesters, AHB slave model with a TX_STAT
// fill level, and a scoreboard of expected DATA writes checked by the slave-side monitor.
module tb_airi5c_uart_tx_arbiter;
  localparam int          NREQ = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] STAT = BASE + 32'd16;

  logic              clk = 1'b0;
  logic              n_reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready;
  logic              hresp;
  logic [2:0]        grant_id;
  logic              busy;
  logic              err;
  logic              err_clr;

  always #5 clk = ~clk;

  airi5c_uart_tx_arbiter #(.BASE_ADDR(BASE), .NUM_REQ(NREQ), .TX_DEPTH(32)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .grant_id(grant_id), .busy(busy), .err(err), .err_clr(err_clr)
  );

  typedef struct packed {
    logic [2:0]  g;
    logic [31:0] a;
    logic [7:0]  d;
  } exp_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] rmem [NREQ][32];
  int         rhead [NREQ];
  int         rtail [NREQ];
  int         nrdy [NREQ];
  logic [7:0] fill;
  int         ws_cfg;
  bit         inj_wr_err;
  int         npoll = 0;
  int         nwr = 0;
  int         wr_poll [256];
  exp_t       sb_q [$];
  int         p0, w0, p1, w1, r0c, r3c, viol, n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NREQ; i++)
      if (rhead[i] != rtail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic lst);
    rmem[r][rtail[r] % 32] = {lst, d};
    rtail[r]++;
  endtask

  task automatic expect_wr(input logic [7:0] d, input logic [2:0] g);
    exp_t e;
    e.g = g;
    e.a = BASE;
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int max);
    int k;
    for (k = 0; k < max; k++) begin
      @(negedge clk);
      if (!busy && queues_empty()) break;
    end
    check({name, "_idle_in_time"}, 32'(k < max), 32'd1);
    repeat (3) @(negedge clk);
    check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    #1;
  endtask

  task automatic clear_bench();
    for (int i = 0; i < NREQ; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    sb_q.delete();
    inj_wr_err = 1'b0;
  endtask

  task automatic do_reset();
    #1 n_reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 clear_bench();
    @(negedge clk);
    #1 n_reset = 1'b1;
  endtask

  // Requester model: pop on each req_ready pulse, present the next queued byte.
  initial begin
    logic [NREQ-1:0]   v;
    logic [8*NREQ-1:0] dat;
    logic [NREQ-1:0]   lst;
    logic [8:0]        ent;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
      nrdy[i]  = 0;
    end
    forever begin
      @(negedge clk);
      if (n_reset) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_ready[i]) begin
            nrdy[i]++;
            check("ready_only_with_valid", 32'(rhead[i] != rtail[i]), 32'd1);
            if (rhead[i] != rtail[i]) rhead[i]++;
          end
        end
      end
      v = '0; dat = '0; lst = '0;
      for (int i = 0; i < NREQ; i++) begin
        v[i] = (rhead[i] != rtail[i]);
        ent  = rmem[i][rhead[i] % 32];
        dat[8*i +: 8] = v[i] ? ent[7:0] : 8'h00;
        lst[i] = v[i] & ent[8];
      end
      req_valid = v;
      req_data  = dat;
      req_last  = lst;
    end
  end

  // AHB slave model and write monitor.
  initial begin
    bit          dp, dp_write, dp_err;
    logic [31:0] dp_addr;
    int          wcnt;
    exp_t        e;
    dp = 0; dp_write = 0; dp_err = 0; dp_addr = '0; wcnt = 0;
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        dp = 0;
        hready = 1'b1;
        hresp  = 1'b0;
      end else if (dp) begin
        if (htrans == 2'd2) check("no_nonseq_in_data_phase", {30'b0, htrans}, 32'd0);
        if (dp_err) begin
          if (!hready) hready = 1'b1;
          else begin
            dp = 0;
            hresp = 1'b0;
          end
        end else if (hready) begin
          if (dp_write) begin
            wr_poll[nwr % 256] = npoll;
            nwr++;
            if (sb_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_write: got data 0x%0h grant %0d, no write expected", hwdata, grant_id);
            end else begin
              e = sb_q.pop_front();
              check("wr_addr", dp_addr, e.a);
              check("wr_data", hwdata, {24'b0, e.d});
              check("wr_grant", {29'b0, grant_id}, {29'b0, e.g});
            end
          end else begin
            npoll++;
            check("poll_addr", dp_addr, STAT);
          end
          dp = 0;
        end else begin
          wcnt--;
          if (wcnt <= 0) hready = 1'b1;
        end
      end else if (htrans == 2'd2) begin
        dp = 1; dp_write = hwrite; dp_addr = haddr; wcnt = ws_cfg; dp_err = 0;
        hrdata = {24'b0, fill};
        if (hwrite && inj_wr_err) begin
          inj_wr_err = 1'b0;
          dp_err = 1;
          hresp  = 1'b1;
          hready = 1'b0;
        end else begin
          hready = (ws_cfg == 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  initial begin
    n_reset = 1'b0; err_clr = 1'b0; fill = 8'd0; ws_cfg = 0; inj_wr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_htrans", {30'b0, htrans}, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_grant", {29'b0, grant_id}, 32'd0);
    check("rst_haddr", haddr, 32'd0);
    check("rst_hwdata", hwdata, 32'd0);
    check("rst_hwrite", 32'(hwrite), 32'd0);
    #1 n_reset = 1'b1;
    @(negedge clk); #1;

    // single requester, empty FIFO
    p0 = npoll; w0 = nwr; r0c = nrdy[0];
    push(0, 8'h48, 1'b0); push(0, 8'h69, 1'b0);
    expect_wr(8'h48, 3'd0); expect_wr(8'h69, 3'd0);
    wait_idle("single", 200);
    check("single_polls", 32'(npoll - p0), 32'd1);
    check("single_writes", 32'(nwr - w0), 32'd2);
    check("single_ready", 32'(nrdy[0] - r0c), 32'd2);
    check("single_busy", 32'(busy), 32'd0);

    // requesters 0 and 2 together, one wait state per data phase
    do_reset();
    ws_cfg = 1; p0 = npoll; w0 = nwr;
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0);
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b0);
    expect_wr(8'h10, 3'd0); expect_wr(8'h20, 3'd2);
    expect_wr(8'h11, 3'd0); expect_wr(8'h21, 3'd2);
    wait_idle("rr", 300);
    check("rr_polls", 32'(npoll - p0), 32'd1);
    check("rr_writes", 32'(nwr - w0), 32'd4);
    ws_cfg = 0;

    // fill 30 leaves two slots, third byte needs a fresh poll
    do_reset();
    fill = 8'd30; p0 = npoll; w0 = nwr;
    push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b0);
    expect_wr(8'h31, 3'd1); expect_wr(8'h32, 3'd1); expect_wr(8'h33, 3'd1);
    wait_idle("fill30", 300);
    check("fill30_polls", 32'(npoll - p0), 32'd2);
    check("fill30_writes", 32'(nwr - w0), 32'd3);
    check("fill30_wr2_polls", 32'(wr_poll[(w0 + 1) % 256] - p0), 32'd1);
    check("fill30_wr3_polls", 32'(wr_poll[(w0 + 2) % 256] - p0), 32'd2);

    // over-full and full FIFO: poll only, until one slot opens
    do_reset();
    fill = 8'd40; p0 = npoll; w0 = nwr; r3c = nrdy[3];
    push(3, 8'h5A, 1'b0);
    expect_wr(8'h5A, 3'd3);
    repeat (20) @(negedge clk);
    check("overfull_writes", 32'(nwr - w0), 32'd0);
    @(posedge clk); #2 fill = 8'd32;
    repeat (30) @(negedge clk);
    check("full_writes", 32'(nwr - w0), 32'd0);
    check("full_ready", 32'(nrdy[3] - r3c), 32'd0);
    check("full_polling", 32'((npoll - p0) >= 10), 32'd1);
    @(posedge clk); #2 fill = 8'd31;
    wait_idle("full", 100);
    check("full_one_write", 32'(nwr - w0), 32'd1);
    check("full_one_ready", 32'(nrdy[3] - r3c), 32'd1);

    // bus error on write data phase
    do_reset();
    fill = 8'd0; w0 = nwr; r0c = nrdy[0];
    inj_wr_err = 1'b1;
    push(0, 8'h77, 1'b0);
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (err) break;
    end
    check("buserr_err_set", 32'(err), 32'd1);
    #1 push(0, 8'h78, 1'b0);
    expect_wr(8'h78, 3'd0);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (htrans != 2'd0) viol++;
    end
    check("buserr_htrans_idle", 32'(viol), 32'd0);
    check("buserr_err_held", 32'(err), 32'd1);
    check("buserr_no_write", 32'(nwr - w0), 32'd0);
    check("buserr_dropped_ready", 32'(nrdy[0] - r0c), 32'd1);
    #1 err_clr = 1'b1;
    @(negedge clk); #1 err_clr = 1'b0;
    check("buserr_err_cleared", 32'(err), 32'd0);
    p1 = npoll; w1 = nwr;
    wait_idle("buserr_resume", 200);
    check("buserr_resume_poll", 32'(npoll - p1), 32'd1);
    check("buserr_resume_write", 32'(nwr - w1), 32'd1);

    // packet lock vs per-byte arbitration (r0 primes rr_ptr to 1)
    do_reset();
    fill = 8'd0; p0 = npoll;
    push(0, 8'h01, 1'b1);
    expect_wr(8'h01, 3'd0);
    wait_idle("pkt_prime", 200);
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b1);
    push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1);
`ifdef UART_ARB_PACKET_EN
    expect_wr(8'hB0, 3'd1); expect_wr(8'hB1, 3'd1); expect_wr(8'hB2, 3'd1);
    expect_wr(8'hA0, 3'd0); expect_wr(8'hA1, 3'd0);
`else
    expect_wr(8'hB0, 3'd1); expect_wr(8'hA0, 3'd0); expect_wr(8'hB1, 3'd1);
    expect_wr(8'hA1, 3'd0); expect_wr(8'hB2, 3'd1);
`endif
    wait_idle("pkt", 300);
    check("pkt_polls", 32'(npoll - p0), 32'd1);

    // asynchronous reset during a write address phase
    do_reset();
    fill = 8'd0; w0 = nwr;
    push(2, 8'h99, 1'b0);
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (htrans == 2'd2 && hwrite) break;
    end
    check("arst_reached_write", 32'(n < 60), 32'd1);
    #1 n_reset = 1'b0;
    #1;
    check("arst_htrans", {30'b0, htrans}, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hwrite", 32'(hwrite), 32'd0);
    repeat (2) @(negedge clk);
    #1 clear_bench();
    @(negedge clk); #1 n_reset = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_no_write", 32'(nwr - w0), 32'd0);
    check("arst_idle_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/airi5c_uart_tx_arbiter.md
Name: airi5c_uart_tx_arbiter

Overview:
AHB-Lite master that shares one airi5c_uart transmit path among NUM_REQ byte-stream requesters. Round-robin arbitration across the requesters. Tracks TX FIFO space by polling TX_STAT, then writes granted bytes to the UART DATA register. Sits between peripheral byte producers and the UART slave port on a dedicated bus segment.

Parameters:
BASE_ADDR, 32'h00000000, UART base address; DATA = BASE_ADDR+0, TX_STAT = BASE_ADDR+16.
NUM_REQ, 4, number of requesters, 2..8.
TX_DEPTH, 32, UART TX FIFO depth (2^TX_ADDR_WIDTH).

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  byte available, per requester
req_data  in  8*NUM_REQ  byte for requester i, at [8*i+7:8*i]
req_last  in  NUM_REQ  final byte of packet (used only with UART_ARB_PACKET_EN)
req_ready  out  NUM_REQ  one-cycle accept pulse, per requester
haddr  out  32  AHB address
hwrite  out  1  AHB write enable
htrans  out  2  0 = IDLE, 2 = NONSEQ
hwdata  out  32  AHB write data, zero-extended byte
hrdata  in  32  AHB read data
hready  in  1  slave ready
hresp  in  1  slave error
grant_id  out  3  index of last granted requester
busy  out  1  FSM not in IDLE
err  out  1  sticky bus error
err_clr  in  1  clears err

Behaviour:
- Reset values: all outputs 0; rr_ptr = 0; credit = 0; FSM = IDLE.
- FSM states: IDLE, POLL_A, POLL_D, ARB, WR_A, WR_D.
- IDLE:
  - If err = 0 and any req_valid is high: go to POLL_A when credit = 0, else go to ARB.
- POLL_A: drive haddr = BASE_ADDR+16, hwrite = 0, htrans = 2 for one cycle, then go to POLL_D.
- POLL_D:
  - htrans = 0. Wait while hready = 0.
  - On hready = 1, set credit = TX_DEPTH - hrdata[7:0]. Saturate at 0 if fill > TX_DEPTH.
  - Then go to ARB if credit > 0, else back to POLL_A (continuous polling).
- ARB:
  - Choose the first i with req_valid[i] = 1, searching from rr_ptr upward with wrap.
  - Latch req_data[i]. Pulse req_ready[i] for exactly one cycle. Set grant_id = i and rr_ptr = i+1 mod NUM_REQ.
  - Go to WR_A.
  - If no req_valid is high, go to IDLE with no pulse.
- WR_A: haddr = BASE_ADDR, hwrite = 1, htrans = 2 for one cycle, then go to WR_D.
- WR_D:
  - hwdata = {24'b0, latched byte}, htrans = 0. Wait for hready = 1.
  - On hready = 1, decrement credit.
  - If credit becomes 0, go to POLL_A when any req_valid is high, else IDLE.
  - If credit stays nonzero, go to ARB.
- Latency: from IDLE with credit > 0, req_ready is asserted in cycle 2 after req_valid is sampled; with zero wait states the write address phase follows the next cycle.
- Bus error: hresp = 1 during POLL_D or WR_D sets err and clears credit, then the FSM goes to IDLE. A byte already accepted by req_ready is dropped. No new transfers start while err = 1. err_clr has priority over setting err only when no error occurs in the same cycle.
- Only one outstanding AHB transfer at a time; htrans never goes NONSEQ while in a data phase.
- req_valid dropping before the grant is legal; the request is ignored.
- Asynchronous reset mid-transfer returns the FSM to IDLE immediately and drives htrans = 0.

Optional Feature:
UART_ARB_PACKET_EN
- Defined: once requester i is granted, ARB keeps selecting only i until a byte with req_last[i] = 1 is accepted. While locked and req_valid[i] = 0, ARB waits in place rather than going to IDLE. rr_ptr advances only on the last byte. A bus error releases the lock.
- Undefined: req_last is ignored; arbitration is per byte.

Test Plan:
- Single requester sends 0x48, 0x69; TX_STAT reads 0 -> one poll, credit = 32, two writes to addr 0x0 with hwdata 0x48 then 0x69, two req_ready pulses, busy returns to 0.
- Requesters 0 and 2 hold valid simultaneously -> grant order 0, 2, 0, 2; grant_id matches each write.
- Slave returns fill = 30 -> exactly 2 writes, then POLL_A re-issued before a third write.
- Slave returns fill = 32 repeatedly -> only polls, no writes and no req_ready, until fill = 31, then one write.
- hresp = 1 on the write data phase -> err = 1, htrans stays 0 despite req_valid; after an err_clr pulse the FSM resumes with a poll.
- UART_ARB_PACKET_EN defined: requester 1 sends 3 bytes with last on the 3rd, requester 0 valid throughout -> writes in order r1, r1, r1, then r0.
